// File: rtl/urv_prefetch_pkg.sv
// urv_prefetch_pkg: shared types and constants for the uRV instruction prefetch unit.
//   fetch_entry_t    : one queued instruction, {pc, ir}
//   PTR_W / CNT_W    : pointer / outstanding-counter widths for the default configuration
//   ptr_width()      : queue pointer width for a given DEPTH
//   cnt_width()      : counter width able to hold 0..n
//   INSN_BYTES       : RV32 instruction size
//   INSN_ALIGN_MASK  : clears the two low address bits
package urv_prefetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    localparam int unsigned DEF_DEPTH           = 4;
    localparam int unsigned DEF_MAX_OUTSTANDING = 2;

    localparam int unsigned PTR_W = $clog2(DEF_DEPTH);
    localparam int unsigned CNT_W = $clog2(DEF_MAX_OUTSTANDING + 1);

    localparam logic [31:0] INSN_BYTES      = 32'd4;
    localparam logic [31:0] INSN_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/urv_prefetch_fifo.sv
// urv_prefetch_fifo: circular instruction queue with flush.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   flush_i        : empties the queue; overrides same-cycle push and pop
//   push_i/wdata_i : enqueue one entry
//   pop_i          : dequeue the head
//   rdata_o        : head entry (meaningful only when !empty_o)
//   empty_o        : queue empty
//   count_o        : occupancy, 0..DEPTH
module urv_prefetch_fifo
    import urv_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 wdata_i,
    input  logic                         pop_i,
    output fetch_entry_t                 rdata_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    fetch_entry_t    r_mem [DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [OccW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push_i && (r_count != OccW'(DEPTH));
    assign w_pop  = pop_i && (r_count != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + OccW'(w_push) - OccW'(w_pop);
        end
    end

    // Storage needs no reset; nothing reads it while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wr_ptr] <= wdata_i;
    end

    assign rdata_o = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

endmodule

// File: rtl/urv_prefetch.sv
// urv_prefetch: pipelined instruction prefetch for the uRV core.
// Issues request/grant fetches, queues responses with their PC, and presents the head to
// decode. A taken branch flushes the queue and squashes responses still in flight.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   im_req_o, im_addr_o     : fetch request and word-aligned address
//   im_gnt_i                : request accepted
//   im_valid_i, im_data_i   : in-order response
//   f_valid_o, f_ir_o, f_pc_o : queue head to decode
//   f_stall_i               : decode not accepting
//   x_bra_i, x_pc_bra_i     : redirect pulse and target
// Build option: define URV_PREFETCH_BYPASS_EN to forward a response straight to decode when
// the queue is empty.
module urv_prefetch
    import urv_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_gnt_i,
    input  logic        im_valid_i,
    input  logic [31:0] im_data_i,
    output logic        f_valid_o,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o,
    input  logic        f_stall_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_pc_bra_i
);

    localparam int unsigned CntW = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic            r_active;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [CntW-1:0] r_outst;
    logic [CntW-1:0] r_discard;

    logic [OccW-1:0] w_count;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wdata;
    logic [31:0]     w_target;
    logic            w_req;
    logic            w_fire;
    logic            w_rsp;
    logic            w_keep;
    logic            w_push;
    logic            w_pop;
    logic            w_bypass;
    logic            w_fifo_push;

    assign w_target = x_pc_bra_i & INSN_ALIGN_MASK;

    // r_active holds requests off for the first cycle after reset release.
    // Each in-flight request reserves a queue slot, so a response always has room.
    assign w_req = r_active && !x_bra_i
                && ((32'(w_count) + 32'(r_outst)) < DEPTH)
                && (32'(r_outst) < MAX_OUTSTANDING);
    assign w_fire = w_req && im_gnt_i;
    assign w_rsp  = r_active && im_valid_i;
    assign w_keep = w_rsp && (r_discard == '0);
    assign w_push = w_keep && !x_bra_i;

    assign im_req_o  = w_req;
    assign im_addr_o = r_fetch_pc;

    always_comb begin
        f_valid_o = !w_empty;
        f_ir_o    = w_empty ? 32'h0 : w_head.ir;
        f_pc_o    = w_empty ? r_rsp_pc : w_head.pc;
        w_bypass  = 1'b0;
`ifdef URV_PREFETCH_BYPASS_EN
        if (w_empty && w_push) begin
            f_valid_o = 1'b1;
            f_ir_o    = im_data_i;
            f_pc_o    = r_rsp_pc;
            w_bypass  = 1'b1;
        end
`endif
    end

    assign w_pop       = !w_empty && !f_stall_i;
    // A bypassed word consumed by decode this cycle never enters the queue.
    assign w_fifo_push = w_push && !(w_bypass && !f_stall_i);
    assign w_wdata     = '{pc: r_rsp_pc, ir: im_data_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_active <= 1'b1;
            r_outst  <= r_outst + CntW'(w_fire) - CntW'(w_rsp);
            if (x_bra_i) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                // Whatever is still in flight after this cycle belongs to the old stream,
                // including the remainder of an earlier squash.
                r_discard  <= r_outst + CntW'(w_fire) - CntW'(w_rsp);
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + INSN_BYTES;
                if (w_keep) r_rsp_pc <= r_rsp_pc + INSN_BYTES;
                if (w_rsp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
            end
        end
    end

    urv_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (x_bra_i),
        .push_i  (w_fifo_push),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .empty_o (w_empty),
        .count_o (w_count)
    );

endmodule

// File: tb/tb_urv_prefetch.sv
// tb_urv_prefetch: randomized bench for urv_prefetch with an in-order memory model and a
// scoreboard of the PC stream decode should observe.
module tb_urv_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
`ifdef URV_PREFETCH_BYPASS_EN
    localparam int          FIRST_LAT = 2;
`else
    localparam int          FIRST_LAT = 3;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_gnt_i;
    logic        im_valid_i;
    logic [31:0] im_data_i;
    logic        f_valid_o;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_stall_i;
    logic        x_bra_i;
    logic [31:0] x_pc_bra_i;

    urv_prefetch #(
        .RESET_PC        (RESET_PC),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .im_req_o   (im_req_o),
        .im_addr_o  (im_addr_o),
        .im_gnt_i   (im_gnt_i),
        .im_valid_i (im_valid_i),
        .im_data_i  (im_data_i),
        .f_valid_o  (f_valid_o),
        .f_ir_o     (f_ir_o),
        .f_pc_o     (f_pc_o),
        .f_stall_i  (f_stall_i),
        .x_bra_i    (x_bra_i),
        .x_pc_bra_i (x_pc_bra_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          gnt_pct = 100;
    int          stall_pct = 0;
    int          valid_total = 0;
    pend_t       pending[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next = RESET_PC;

    logic        prev_req, prev_gnt, prev_bra, prev_valid, prev_stall;
    logic [31:0] prev_addr, prev_tgt, prev_pc, prev_ir;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_true(input bit ok, input string name, input logic [31:0] act,
                            input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: scoreboard, protocol checks and memory bookkeeping, all at the falling edge.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            pending.delete();
            exp_q.delete();
            exp_next   = RESET_PC;
            prev_req   = 1'b0;
            prev_gnt   = 1'b0;
            prev_bra   = 1'b0;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (f_valid_o) valid_total++;
            if (x_bra_i) begin
                chk_eq("req_low_on_redirect", {31'b0, im_req_o}, 32'h0);
                exp_q.delete();
                exp_next = x_pc_bra_i & 32'hFFFF_FFFC;
            end else if (f_valid_o && !f_stall_i) begin
                logic [31:0] e;
                while (exp_q.size() < 4) begin
                    exp_q.push_back(exp_next);
                    exp_next = exp_next + 32'd4;
                end
                e = exp_q.pop_front();
                chk_eq("pop_pc", f_pc_o, e);
                chk_eq("pop_ir", f_ir_o, mem_word(e));
            end
            if (im_req_o) begin
                chk_true(pending.size() < MAX_OUT, "max_outstanding", pending.size(), MAX_OUT);
                chk_eq("addr_aligned", {30'b0, im_addr_o[1:0]}, 32'h0);
            end
            if (prev_bra)
                chk_eq("valid_low_after_redirect", {31'b0, f_valid_o}, 32'h0);
            if (prev_bra && !x_bra_i && im_req_o)
                chk_eq("first_addr_after_redirect", im_addr_o, prev_tgt);
            if (prev_req && !prev_gnt && !prev_bra && !x_bra_i) begin
                chk_eq("req_held", {31'b0, im_req_o}, 32'h1);
                chk_eq("addr_held", im_addr_o, prev_addr);
            end
            if (prev_valid && prev_stall && !prev_bra && !x_bra_i) begin
                chk_eq("stall_valid_held", {31'b0, f_valid_o}, 32'h1);
                chk_eq("stall_pc_held", f_pc_o, prev_pc);
                chk_eq("stall_ir_held", f_ir_o, prev_ir);
            end
            if (im_valid_i) void'(pending.pop_front());
            if (im_req_o && im_gnt_i) pending.push_back('{addr: im_addr_o, due: cyc + lat});
            prev_req   = im_req_o;
            prev_gnt   = im_gnt_i;
            prev_addr  = im_addr_o;
            prev_bra   = x_bra_i;
            prev_tgt   = x_pc_bra_i & 32'hFFFF_FFFC;
            prev_valid = f_valid_o;
            prev_stall = f_stall_i;
            prev_pc    = f_pc_o;
            prev_ir    = f_ir_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // st: 0 = no stall, 1 = stall, 2 = random stall
    task automatic drive(input bit do_bra, input logic [31:0] tgt, input int st);
        im_gnt_i   = (int'($urandom_range(99)) < gnt_pct);
        im_valid_i = 1'b0;
        im_data_i  = 32'h0;
        if (rst_n_i && pending.size() > 0 && pending[0].due <= cyc) begin
            im_valid_i = 1'b1;
            im_data_i  = mem_word(pending[0].addr);
        end
        f_stall_i  = (st == 2) ? (int'($urandom_range(99)) < stall_pct) : (st == 1);
        x_bra_i    = do_bra;
        x_pc_bra_i = do_bra ? tgt : $urandom;
    endtask

    task automatic cycle(input bit do_bra, input logic [31:0] tgt, input int st);
        tick();
        drive(do_bra, tgt, st);
    endtask

    task automatic quiet_inputs();
        im_gnt_i   = 1'b0;
        im_valid_i = 1'b0;
        im_data_i  = 32'h0;
        f_stall_i  = 1'b0;
        x_bra_i    = 1'b0;
        x_pc_bra_i = 32'h0;
    endtask

    task automatic release_reset();
        @(posedge clk_i);
        #1;
        cyc     = 0;
        rst_n_i = 1'b1;
        drive(1'b0, 32'h0, 0);
    endtask

    initial begin
        int          base;
        bit          hit;
        bit          b;
        logic [31:0] tgt;

        rst_n_i = 1'b0;
        quiet_inputs();
        repeat (3) @(posedge clk_i);
        #1;
        chk_eq("reset_valid", {31'b0, f_valid_o}, 32'h0);
        chk_eq("reset_req", {31'b0, im_req_o}, 32'h0);
        chk_eq("reset_pc", f_pc_o, RESET_PC);
        chk_eq("reset_ir", f_ir_o, 32'h0);

        // Streaming: grant every cycle, latency 1, no stall.
        lat = 1; gnt_pct = 100; stall_pct = 0;
        release_reset();
        chk_eq("first_req_wait", {31'b0, im_req_o}, 32'h0);
        base = valid_total;
        repeat (30) cycle(1'b0, 32'h0, 0);
        chk_eq("stream_valid_cycles", valid_total - base, 30 - FIRST_LAT);

        // Stall for 10 cycles: queue plus in-flight fills to DEPTH and requests stop.
        repeat (10) cycle(1'b0, 32'h0, 1);
        chk_eq("stall_req_dropped", {31'b0, im_req_o}, 32'h0);
        chk_eq("stall_valid", {31'b0, f_valid_o}, 32'h1);
        chk_eq("stall_in_flight", pending.size(), 32'h0);
        repeat (20) cycle(1'b0, 32'h0, 0);

        // Latency 3 with sparse grants and random stalls.
        lat = 3; gnt_pct = 50; stall_pct = 30;
        repeat (300) cycle(1'b0, 32'h0, 2);

        // Branch to 0x100 while two requests are outstanding.
        gnt_pct = 100; stall_pct = 0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (pending.size() == MAX_OUT) begin
                drive(1'b1, 32'h100, 0);
                hit = 1'b1;
            end else begin
                drive(1'b0, 32'h0, 0);
            end
        end
        chk_eq("two_outstanding_reached", {31'b0, hit}, 32'h1);
        repeat (30) cycle(1'b0, 32'h0, 0);

        // Redirect with a response and a pop in the same cycle, then a second redirect.
        lat = 1;
        repeat (5) cycle(1'b0, 32'h0, 0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            drive(1'b0, 32'h0, 0);
            if (f_valid_o && im_valid_i) begin
                drive(1'b1, 32'h180, 0);
                hit = 1'b1;
            end
        end
        chk_eq("redirect_with_valid_reached", {31'b0, hit}, 32'h1);
        cycle(1'b1, 32'h202, 0);
        base = valid_total;
        repeat (30) cycle(1'b0, 32'h0, 0);
        chk_eq("double_redirect_valid_cycles", valid_total - base, 30 - FIRST_LAT);

        // Fully random traffic with redirects, including targets near the address wrap.
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) begin
                lat       = int'($urandom_range(3, 1));
                gnt_pct   = int'($urandom_range(100, 40));
                stall_pct = int'($urandom_range(50, 0));
            end
            tick();
            b   = (int'($urandom_range(99)) < 4);
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                            : ($urandom & 32'h0000_FFFF);
            drive(b, tgt, 2);
        end

        // Asynchronous reset in the middle of a burst.
        lat = 1; gnt_pct = 100; stall_pct = 0;
        repeat (10) cycle(1'b0, 32'h0, 0);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_eq("async_rst_valid", {31'b0, f_valid_o}, 32'h0);
        chk_eq("async_rst_req", {31'b0, im_req_o}, 32'h0);
        chk_eq("async_rst_pc", f_pc_o, RESET_PC);
        quiet_inputs();
        repeat (2) @(posedge clk_i);
        release_reset();
        cycle(1'b0, 32'h0, 0);
        chk_eq("restart_req", {31'b0, im_req_o}, 32'h1);
        chk_eq("restart_addr", im_addr_o, RESET_PC);
        base = valid_total;
        repeat (29) cycle(1'b0, 32'h0, 0);
        chk_eq("restart_valid_cycles", valid_total - base, 30 - FIRST_LAT);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
